mac_acc_tc_40: RTL

- Downstream consumer of the 16x16 two's-complement multiplier: accepts a stream of signed 32-bit products over a valid/ready handshake.
- Accumulates the products into a sign-extended accumulator and emits one sum per frame, where a frame is terminated by in_last.
- Sits between the combinational multiplier array and any result sink (dot-product / FIR output stage).

---
 rtl/mac_acc_tc_40_if.sv | 26 ++
 rtl/mac_acc_tc_40.sv | 114 +++++++++++
 2 files changed

// File: rtl/mac_acc_tc_40_if.sv
// Product-in / frame-sum-out stream bundle for mac_acc_tc_40.
// The master drives the product stream and out_ready. The slave is the accumulator.
interface mac_acc_tc_40_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mac_acc_tc_40.sv
// Signed frame accumulator for 32-bit products; one sum per in_last frame. MAC_ACC_TC_40_SAT_EN selects saturating add.
// Latency: out_valid rises on the first edge after the in_last product is accepted.
// Backpressure: in_ready drops while a result is held; one bubble per frame after out_ready handshake.
module mac_acc_tc_40 #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_acc_tc_40_if.slave   bus
);
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             out_ovf_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum_raw;
    logic [ACC_W-1:0] nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_now;
    logic             accept;

    assign prod_ext = {{(ACC_W-32){bus.in_product[31]}}, bus.in_product};
    assign sum_raw  = acc_q + prod_ext;

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf_now  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_ACC_TC_40_SAT_EN
    always_comb begin
        nxt = sum_raw;
        if (ovf_now) begin
            nxt = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign nxt = sum_raw;
`endif

    // Term counter sticks at all-ones rather than wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ACC: begin
                accept = bus.in_valid;
                if (bus.in_valid && bus.in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            out_ovf_q <= 1'b0;
        end else if (accept) begin
            if (bus.in_last) begin
                sum_q     <= nxt;
                count_q   <= cnt_inc;
                out_ovf_q <= ovf_q | ovf_now;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else begin
                acc_q     <= nxt;
                cnt_q     <= cnt_inc;
                ovf_q     <= ovf_q | ovf_now;
            end
        end
    end

    // Handshake flags depend on state only, so no input-to-output combinational path.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
